// File: rtl/if_id_stage_pkg.sv
// Shared constants for the fetch stage and IF/ID register.
package if_id_stage_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INC           = 32'd4;

  // Register-field positions inside a MIPS instruction word.
  localparam int unsigned RS_MSB = 25;
  localparam int unsigned RS_LSB = 21;
  localparam int unsigned RT_MSB = 20;
  localparam int unsigned RT_LSB = 16;

  // Instructions are word aligned; the low two PC bits are always zero.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_stage_if.sv
// Control, instruction-memory and IF/ID bundle of the fetch stage.
interface if_id_stage_if;

  logic        PCWrite;
  logic        IF_IDWrite;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] imem_rdata;
  logic [31:0] imem_addr;
  logic [31:0] IF_ID_PC4;
  logic [31:0] IF_ID_Instr;
  logic        IF_ID_Valid;
  logic [4:0]  IF_ID_Rs;
  logic [4:0]  IF_ID_Rt;

  // Surrounding pipeline: hazard unit, ID stage and instruction memory.
  modport master (
    output PCWrite, IF_IDWrite, branch_taken, branch_target, jump,
           jump_target, imem_rdata,
    input  imem_addr, IF_ID_PC4, IF_ID_Instr, IF_ID_Valid, IF_ID_Rs, IF_ID_Rt
  );

  // The fetch stage itself.
  modport slave (
    input  PCWrite, IF_IDWrite, branch_taken, branch_target, jump,
           jump_target, imem_rdata,
    output imem_addr, IF_ID_PC4, IF_ID_Instr, IF_ID_Valid, IF_ID_Rs, IF_ID_Rt
  );

endinterface

// File: rtl/if_id_stage_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Increment on event unless already saturated.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/if_id_stage.sv
// Fetch stage: PC register, next-PC selection and IF/ID pipeline register.
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  if_id_stage_if.slave     bus,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4;
  logic [31:0] instr_q;
  logic [31:0] instr_d;
  logic [31:0] pc4_q;
  logic [31:0] pc4_d;
  logic        valid_q;
  logic        valid_d;
  logic        redir;
  logic        stall;
  logic [31:0] redir_target;

  assign pc_plus4 = pc_q + PC_INC;

  // A stalled ID instruction is unresolved, so its branch/jump is ignored.
  assign redir        = (bus.branch_taken | bus.jump) & bus.IF_IDWrite;
  assign stall        = ~redir & ~bus.IF_IDWrite;
  assign redir_target = bus.jump ? bus.jump_target : bus.branch_target;

  // Next PC: redirect overrides PCWrite; otherwise advance or hold.
  always_comb begin
    pc_d = pc_q;
    if (redir) begin
      pc_d = align_pc(redir_target);
    end else if (bus.PCWrite) begin
      pc_d = align_pc(pc_plus4);
    end
  end

  // Next IF/ID contents: flush on redirect, load on write, else hold.
  always_comb begin
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (redir) begin
      instr_d = NOP_INSTR;
      pc4_d   = '0;
      valid_d = 1'b0;
    end else if (bus.IF_IDWrite) begin
      instr_d = bus.imem_rdata;
      pc4_d   = pc_plus4;
      valid_d = 1'b1;
    end
  end

  // PC register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= align_pc(RESET_PC);
    end else begin
      pc_q <= pc_d;
    end
  end

  // IF/ID pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= NOP_INSTR;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (redir),
    .count (flush_cnt)
  );

  assign bus.imem_addr   = pc_q;
  assign bus.IF_ID_PC4   = pc4_q;
  assign bus.IF_ID_Instr = instr_q;
  assign bus.IF_ID_Valid = valid_q;
  assign bus.IF_ID_Rs    = instr_q[RS_MSB:RS_LSB];
  assign bus.IF_ID_Rt    = instr_q[RT_MSB:RT_LSB];

endmodule

// File: doc/if_id_stage.md
# if_id_stage

Fetch stage plus IF/ID pipeline register of the five-stage MIPS core. Holds the PC, drives the instruction-memory address, and latches the fetched instruction with PC+4 into IF/ID. It obeys the PCWrite/IF_IDWrite stall controls from the hazard detection unit and the branch/jump redirect from ID. It also supplies the IF/ID Rs/Rt fields that the hazard unit compares against.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- CNT_W, 16, width of the stall and flush event counters
- clk  in  1  pipeline clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- PCWrite  in  1  from hazard unit; 0 holds PC
- IF_IDWrite  in  1  from hazard unit; 0 holds IF/ID
- branch_taken  in  1  ID-stage branch resolved taken
- branch_target  in  32  branch target address
- jump  in  1  ID-stage j/jal
- jump_target  in  32  jump target address
- imem_rdata  in  32  combinational instruction-memory read data
- imem_addr  out  32  current PC, to instruction memory
- IF_ID_PC4  out  32  latched PC+4
- IF_ID_Instr  out  32  latched instruction
- IF_ID_Valid  out  1  IF/ID holds a real instruction
- IF_ID_Rs  out  5  IF_ID_Instr[25:21]
- IF_ID_Rt  out  5  IF_ID_Instr[20:16]
- stall_cnt  out  CNT_W  saturating count of stall cycles
- flush_cnt  out  CNT_W  saturating count of flushes

## Operation
- Reset (rst_n=0, asynchronous): PC=RESET_PC, IF_ID_Instr=32'h0 (NOP), IF_ID_PC4=0, IF_ID_Valid=0, both counters=0.
- Redirect qualifier: `redir = (branch_taken | jump) & IF_IDWrite`. Branch/jump inputs are ignored while IF/ID is stalled, because the ID instruction is not yet resolved.
- Redirect target: jump_target if jump; else branch_target. Jump wins when both are asserted.
- Per edge, priority order:
  1. **redir**: PC ← target, regardless of PCWrite. IF/ID flushed: Instr=0, PC4=0, Valid=0. flush_cnt+1.
  2. **Stall** (!redir and IF_IDWrite=0): IF/ID holds. PC holds if PCWrite=0. stall_cnt+1.
  3. **Normal**: if PCWrite, PC ← PC+4. If IF_IDWrite, IF/ID ← {imem_rdata, PC+4}, Valid=1.
- PCWrite=1 with IF_IDWrite=0: PC advances and IF/ID holds. This is a legal input but is not produced by the hazard unit; it is not counted as a flush.
- PCWrite=0 with IF_IDWrite=1: PC holds and IF/ID reloads the same instruction. This is legal.
- Arithmetic: PC+4 is a 32-bit add with wrap; 32'hFFFF_FFFC+4 = 0. PC[1:0] is forced to 0 on every load, including targets.
- Counters saturate at all-ones and never wrap.
- IF_ID_Rs and IF_ID_Rt are combinational slices of the IF_ID_Instr register, not of imem_rdata.

## Timing
- imem_addr equals the PC register and changes only on clk edges or reset.
- Fetch latency: the instruction at PC appears on IF_ID_Instr one edge after imem_addr=PC, provided IF_IDWrite=1.
- Branch penalty: one bubble. The instruction fetched in the cycle redir is high is discarded. The target instruction enters IF/ID two edges after redir.
- Stall: for N cycles of IF_IDWrite=0, IF/ID holds for exactly N edges and stall_cnt increments by N.
- Reset mid-operation clears state immediately, without waiting for an edge. The first fetch after rst_n rises is from RESET_PC.
- All outputs are registered except IF_ID_Rs and IF_ID_Rt, which are wire slices of registers.

## Structure
- Shared package: NOP_INSTR=32'h0, RESET_PC default, instruction field positions (RS_MSB/LSB, RT_MSB/LSB), PC_INC=4.
- Sub-module: sat_counter (parameter W; inputs inc, clk, rst_n), instantiated for stall_cnt and flush_cnt.
- PC register, next-PC mux and IF/ID register stay in if_id_stage.

## Test plan
- Reset then 3 free-running cycles with imem_rdata = 32'h8C01_0004, 32'h0022_1820, 32'hAC03_0008 → IF_ID_PC4 = 4, 8, 12 in order; Valid=1 from the first edge.
- Stall: PCWrite=IF_IDWrite=0 for 2 cycles at PC=8 → imem_addr stays 8, IF_ID_Instr unchanged, stall_cnt=2; fetch resumes at 8.
- Branch: branch_taken=1, target=32'h40 at PC=12 → next edge PC=32'h40, IF_ID_Instr=0, Valid=0, flush_cnt=1; following edge IF_ID_PC4=32'h44.
- Branch during stall: branch_taken=1 with IF_IDWrite=0, PCWrite=0 → no redirect, PC holds, flush_cnt unchanged.
- Branch and jump together: jump_target=32'h100, branch_target=32'h40 → PC=32'h100. Misaligned target 32'h103 → PC=32'h100.
- Reset asserted mid-stream at PC=32'h40 with counters nonzero → all outputs return to reset values asynchronously. Counter saturation check with CNT_W=2: 5 stalls → stall_cnt=3.
